// File: rtl/matricula_pkg.sv
// Shared constants, state type and slot-mask helper for the matricula entry block.
package matricula_pkg;

  localparam int N_DIGITS = 6;
  localparam int DIGIT_W  = 4;
  localparam int MAT_W    = N_DIGITS * DIGIT_W;
  localparam int CNT_W    = 3;

  // Largest decimal digit code; anything above is hex-only.
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_DEC = 4'd9;

  // Digit count at which the word is complete.
  localparam logic [CNT_W-1:0] CNT_FULL = 3'(N_DIGITS);

  typedef enum logic {
    ENTRY = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Expand a one-hot slot enable into a nibble mask; slot 0 is the top nibble.
  function automatic logic [MAT_W-1:0] slot_mask(input logic [N_DIGITS-1:0] en);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      m[MAT_W-1-k*DIGIT_W -: DIGIT_W] = {DIGIT_W{en[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/matricula_slot_dec.sv
// Slot index -> one-hot write enable. Indices >= N_DIGITS give no enable,
// which keeps a full word and an underflowed index from touching any slot.
module matricula_slot_dec
  import matricula_pkg::*;
(
  input  logic [CNT_W-1:0]    i_idx,
  output logic [N_DIGITS-1:0] o_slot_en
);

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_slot
      assign o_slot_en[gi] = (i_idx == CNT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/matricula_entry.sv
// Sequential six-digit matricula collector with delete, clear and a
// valid/ready hand-off of the completed word.
module matricula_entry
  import matricula_pkg::*;
#(
  parameter bit HEX_OK = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               del,
  input  logic               clr,
  output logic [MAT_W-1:0]   matricula,
  output logic [CNT_W-1:0]   count,
  output logic               mat_valid,
  input  logic               mat_ready,
  output logic               err
);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_count, w_count_next;
  logic [MAT_W-1:0]    r_mat, w_mat_next;
  logic                r_mat_valid;
  logic                r_err, w_err_next;

  logic [CNT_W-1:0]    w_dec_idx;
  logic [N_DIGITS-1:0] w_slot_en;
  logic [MAT_W-1:0]    w_slot_mask;
  logic [MAT_W-1:0]    w_digit_rep;
  logic                w_digit_ok;

  // Delete targets the last filled slot, a new digit the first empty one;
  // del outranks digit_valid so one decoder serves both.
  assign w_dec_idx   = del ? (r_count - 3'd1) : r_count;
  assign w_slot_mask = slot_mask(w_slot_en);
  assign w_digit_rep = {N_DIGITS{digit}};
  assign w_digit_ok  = HEX_OK || (digit <= DIGIT_MAX_DEC);

  matricula_slot_dec u_slot_dec (
    .i_idx     (w_dec_idx),
    .o_slot_en (w_slot_en)
  );

  // State, counter, word and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ENTRY;
      r_count     <= '0;
      r_mat       <= '0;
      r_mat_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_mat       <= w_mat_next;
      r_mat_valid <= (w_state_next == DONE);
      r_err       <= w_err_next;
    end
  end

  // Next-state: clr > del > (handshake | digit); only the winner acts.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_mat_next   = r_mat;
    w_err_next   = 1'b0;
    if (clr) begin
      w_state_next = ENTRY;
      w_count_next = '0;
      w_mat_next   = '0;
    end else if (del) begin
      if (r_count == '0) begin
        w_err_next = 1'b1;
      end else begin
        w_mat_next   = r_mat & ~w_slot_mask;
        w_count_next = r_count - 3'd1;
        w_state_next = ENTRY;
      end
    end else if (r_state == DONE) begin
      if (mat_ready) begin
        w_state_next = ENTRY;
        w_count_next = '0;
        w_mat_next   = '0;
      end
      // A digit has no slot in a full word, even in the transfer cycle.
      if (digit_valid) begin
        w_err_next = 1'b1;
      end
    end else if (digit_valid) begin
      if (!w_digit_ok) begin
        w_err_next = 1'b1;
      end else begin
        w_mat_next   = (r_mat & ~w_slot_mask) | (w_digit_rep & w_slot_mask);
        w_count_next = r_count + 3'd1;
        if (r_count == CNT_FULL - 3'd1) begin
          w_state_next = DONE;
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    matricula = r_mat;
    count     = r_count;
    mat_valid = r_mat_valid;
    err       = r_err;
  end

endmodule

// File: doc/matricula_entry.md
# matricula_entry

Sequential digit collector that assembles a 24-bit matricula word from six 4-bit digits entered one at a time (keypad or switch strobe). It is the write-side counterpart of the matricula nibble splitter. It feeds the display/storage path with a packed word whose first-entered digit occupies the most significant nibble (A = [23:20] … F = [3:0]). It supports delete, clear, and a valid/ready hand-off of the completed word.

## Interface
- N_DIGITS, 6, number of nibbles per matricula.
- DIGIT_W, 4, bits per digit; word width = N_DIGITS*DIGIT_W.
- HEX_OK, 0, 1 accepts digit codes 0xA–0xF; 0 rejects codes above 9.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- digit_valid  in  1  one-cycle strobe: digit is presented.
- digit  in  4  digit code, sampled when digit_valid=1.
- del  in  1  one-cycle strobe: remove last entered digit.
- clr  in  1  one-cycle strobe: discard whole entry.
- matricula  out  24  packed word; unfilled slots read 0.
- count  out  3  digits currently held (0..6).
- mat_valid  out  1  word complete and offered downstream.
- mat_ready  in  1  downstream accepts word when mat_valid=1.
- err  out  1  one-cycle pulse on a rejected input.

## Operation
- States: ENTRY (count 0..5) and DONE (count = 6, mat_valid = 1).
- Input priority in any cycle: clr > del > digit_valid. Only the winning input acts.
- ENTRY, accepted digit: written to slot count, where slot k = bits [23-4k : 20-4k]. count increments. When the write makes count 6, go to DONE.
- ENTRY, digit rejected (HEX_OK=0 and digit > 9): no store, count unchanged, err pulses.
- ENTRY, del: if count > 0, zero slot count-1 and decrement count. If count = 0, err pulses and nothing changes.
- clr in any state: matricula = 0, count = 0, go to ENTRY. No err.
- DONE, digit_valid: ignored, err pulses.
- DONE, del: zero slot 5, count = 5, drop mat_valid, return to ENTRY.
- DONE, mat_valid & mat_ready: handshake completes. Next cycle matricula = 0, count = 0, state ENTRY.
- Handshake vs. input conflict: mat_ready is examined only when no clr/del is present.
  - clr or del in the same cycle as mat_ready wins; the word is not transferred.
  - digit_valid in the same cycle as a successful transfer is dropped with err.
- matricula, count and mat_valid are direct register outputs. Nibbles in slots ≥ count are always 0.

## Timing
- Reset (async assert, sync-safe deassert): matricula = 0, count = 0, mat_valid = 0, err = 0, state ENTRY.
- Reset mid-entry or while DONE discards the word immediately; no hand-off occurs.
- Latency:
  - Input strobe at edge n → matricula/count updated after edge n.
  - 6th digit at edge n → mat_valid = 1 after edge n.
- err is high for exactly the cycle following the offending strobe.
- mat_valid stays high, with matricula stable, until transfer, del, clr or reset.
- Held strobes act once per cycle they are high. Strobes are expected to be one cycle wide; debouncing is upstream.

## Structure
- Shared package matricula_pkg holds:
  - N_DIGITS, DIGIT_W, MAT_W constants;
  - the state type {ENTRY, DONE};
  - helper constant DIGIT_MAX_DEC = 9.
- Sub-module matricula_slot_dec: count (3 b) → 6-bit one-hot slot write enable, used for both digit write and del clear. Combinational, about 20 lines.
- Top holds the FSM, counter, 24-bit register and err flop.

## Test plan
- Reset, then enter 1,2,3,4,5,6 on consecutive cycles with mat_ready = 0 → matricula = 0x123456, count = 6, mat_valid = 1 one cycle after the 6th strobe and held for 10 cycles.
- From that state, pulse mat_ready → next cycle matricula = 0, count = 0, mat_valid = 0. A digit 7 strobed in the ready cycle → err pulse, not stored.
- Enter 9,8,7, then del, then 5 → matricula = 0x985000, count = 3. Entering del at count 0 → err pulse, outputs unchanged.
- HEX_OK = 0: strobe digit 0xB at count 2 → err = 1 for one cycle, matricula and count unchanged. With HEX_OK = 1 the same strobe stores 0xB.
- In DONE, assert clr, del and mat_ready in the same cycle → clr wins: matricula = 0, count = 0, no transfer observed.
- Enter 4 digits (0x4321), then assert rst_n = 0 asynchronously between edges → outputs go to 0 immediately. After release, entry restarts at slot 0.
